// File: rtl/mul_pkg.sv
// Shared multiplier-datapath types and default widths, used by the Wallace
// slice wrapper, the final carry-propagate adder and the writeback stage.
package mul_pkg;

  localparam int MUL_WIDTH = 32;
  localparam int MUL_TAG_W = 4;

  typedef struct packed {
    logic [MUL_WIDTH-1:0] sum;
    logic [MUL_WIDTH-1:0] carry;
  } csa_pair_t;

  typedef struct packed {
    logic [MUL_WIDTH-1:0] result;
    logic                 ovf;
    logic [MUL_TAG_W-1:0] tag;
  } mul_result_t;

endpackage

// File: rtl/cpa_seg.sv
// Combinational N-bit carry-propagate adder segment with carry-in and carry-out.
module cpa_seg #(
  parameter int N = 16
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};

endmodule

// File: rtl/csa_final_adder.sv
// Resolves a carry-save sum/carry pair into one binary word behind a valid/ready
// pipeline. Define CSA_FINAL_ADDER_SPLIT_EN to split the adder into two half-width stages.
module csa_final_adder
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH,
  parameter int TAG_W = MUL_TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic [WIDTH-1:0] in_carry,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_ovf,
  output logic [TAG_W-1:0] out_tag
);

  // Output stage, common to both builds.
  logic             v_out;
  logic [WIDTH-1:0] res_q;
  logic             ovf_q;
  logic [TAG_W-1:0] tag_q;
  logic             out_stage_ready;

  // NOTE: ready is combinational from out_ready so a full pipe still takes one per cycle.
  assign out_stage_ready = !v_out || out_ready;

  assign out_valid  = v_out;
  assign out_result = res_q;
  assign out_ovf    = ovf_q;
  assign out_tag    = tag_q;

`ifdef CSA_FINAL_ADDER_SPLIT_EN

  localparam int LO = WIDTH / 2;

  logic          lo_cout;
  logic [LO-1:0] lo_s;
  logic          v1;
  logic [LO-1:0] lo_q;
  logic          lo_c_q;
  logic [LO-1:0] hi_sum_q;
  logic [LO:0]   hi_carry_q;   // in_carry[WIDTH-1:LO-1]; MSB lands at weight 2^WIDTH
  logic [TAG_W-1:0] tag1_q;
  logic [LO-1:0] hi_s;
  logic          hi_cout;
  logic          adv1;

  cpa_seg #(.N(LO)) u_lo (
    .a    (in_sum[LO-1:0]),
    .b    ({in_carry[LO-2:0], 1'b0}),
    .cin  (1'b0),
    .s    (lo_s),
    .cout (lo_cout)
  );

  cpa_seg #(.N(LO)) u_hi (
    .a    (hi_sum_q),
    .b    (hi_carry_q[LO-1:0]),
    .cin  (lo_c_q),
    .s    (hi_s),
    .cout (hi_cout)
  );

  assign adv1     = v1 && out_stage_ready;
  assign in_ready = !v1 || out_stage_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
    end else if (in_ready) begin
      v1 <= in_valid;
    end
  end

  // NOTE: middle-stage payload is not reset; its valid bit alone decides whether it is used.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      lo_q       <= lo_s;
      lo_c_q     <= lo_cout;
      hi_sum_q   <= in_sum[WIDTH-1:LO];
      hi_carry_q <= in_carry[WIDTH-1:LO-1];
      tag1_q     <= in_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_out <= 1'b0;
      res_q <= '0;
      ovf_q <= 1'b0;
      tag_q <= '0;
    end else begin
      if (out_stage_ready) v_out <= v1;
      if (adv1) begin
        res_q <= {hi_s, lo_q};
        ovf_q <= hi_cout | hi_carry_q[LO];
        tag_q <= tag1_q;
      end
    end
  end

`else

  logic [WIDTH-1:0] full_s;
  logic             full_cout;

  cpa_seg #(.N(WIDTH)) u_full (
    .a    (in_sum),
    .b    ({in_carry[WIDTH-2:0], 1'b0}),
    .cin  (1'b0),
    .s    (full_s),
    .cout (full_cout)
  );

  assign in_ready = out_stage_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      v_out <= 1'b0;
      res_q <= '0;
      ovf_q <= 1'b0;
      tag_q <= '0;
    end else begin
      if (out_stage_ready) v_out <= in_valid;
      if (in_valid && out_stage_ready) begin
        res_q <= full_s;
        ovf_q <= full_cout | in_carry[WIDTH-1];
        tag_q <= in_tag;
      end
    end
  end

`endif

endmodule
